// File: rtl/ppu_cpu_bridge_if.sv
// Host-side access bus of the PPU bridge: level request held until a one-cycle ack.
interface ppu_cpu_bridge_if;
  localparam int unsigned AddrW = 3;
  localparam int unsigned DataW = 8;

  logic             req;
  logic             we;
  logic [AddrW-1:0] addr;
  logic [DataW-1:0] wdata;
  logic             ack;
  logic [DataW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ppu_cpu_bridge.sv
// Host-to-PPU register bridge: sequences RS/RnW/D around an n_DBE strobe with
// programmable setup/enable/hold phases and synchronises the PPU interrupt.
// Optional OAM DMA engine compiled in with `define PPU_BRIDGE_OAMDMA_EN.
module ppu_cpu_bridge #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned DBE_CYC   = 4,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                CLK,
  input  logic                RES,
  ppu_cpu_bridge_if.slave     host,
  output logic                RnW,
  output logic [2:0]          RS,
  output logic                n_DBE,
  output logic [7:0]          D_out,
  output logic                D_oe,
  input  logic [7:0]          D_in,
  input  logic                n_INT,
  output logic                irq,
  input  logic                dma_start,
  output logic                dma_rd,
  output logic [7:0]          dma_idx,
  input  logic                dma_valid,
  input  logic [7:0]          dma_data,
  output logic                dma_busy,
  output logic                dma_done
);

  localparam int unsigned CntW  = 4;
  localparam int unsigned AddrW = 3;
  localparam int unsigned DataW = 8;
  localparam int unsigned IdxW  = 8;

`ifdef PPU_BRIDGE_OAMDMA_EN
  localparam logic DmaEn = 1'b1;
`else
  localparam logic DmaEn = 1'b0;
`endif

  localparam logic [CntW-1:0]  SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0]  DbeLd   = CntW'(DBE_CYC - 1);
  localparam logic [CntW-1:0]  HoldLd  = CntW'(HOLD_CYC - 1);
  localparam logic [AddrW-1:0] OamReg  = AddrW'(4);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] ENABLE   = 3'd2;
  localparam logic [2:0] HOLD     = 3'd3;
  localparam logic [2:0] ACK      = 3'd4;
  localparam logic [2:0] DMA_RD   = 3'd5;
  localparam logic [2:0] DMA_WAIT = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [DataW-1:0] rdcap_q, rdcap_d;
  logic [DataW-1:0] rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             done_q, done_d;

  logic             rnw_q, rnw_d;
  logic [AddrW-1:0] rs_q, rs_d;
  logic             n_dbe_q, n_dbe_d;
  logic [DataW-1:0] d_out_q, d_out_d;
  logic             d_oe_q, d_oe_d;
  logic             ack_q, ack_d;
  logic             dma_rd_q, dma_rd_d;
  logic             bus_act;

  logic             int_s1_q, irq_q;

  // Next-state, phase counter and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdcap_d = rdcap_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (DmaEn && dma_start) begin
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = DMA_RD;
        end else if (host.req) begin
          we_d    = host.we;
          addr_d  = host.addr;
          wdata_d = host.wdata;
          cnt_d   = SetupLd;
          state_d = SETUP;
        end
      end
      DMA_RD: state_d = DMA_WAIT;
      DMA_WAIT: begin
        if (dma_valid) begin
          we_d    = 1'b1;
          addr_d  = OamReg;
          wdata_d = dma_data;
          cnt_d   = SetupLd;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = DbeLd;
          state_d = ENABLE;
        end else begin
          cnt_d = CntW'(cnt_q - CntW'(1));
        end
      end
      ENABLE: begin
        if (cnt_q == '0) begin
          if (!we_q) rdcap_d = D_in;
          cnt_d   = HoldLd;
          state_d = HOLD;
        end else begin
          cnt_d = CntW'(cnt_q - CntW'(1));
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = CntW'(cnt_q - CntW'(1));
        end else if (busy_q) begin
          if (idx_q == '1) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = IdxW'(idx_q + IdxW'(1));
            state_d = DMA_RD;
          end
        end else begin
          if (!we_q) rdata_d = rdcap_q;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus pins follow the state being entered so they are registered
    bus_act  = (state_d == SETUP) || (state_d == ENABLE) || (state_d == HOLD);
    rs_d     = bus_act ? addr_d : '0;
    rnw_d    = bus_act ? ~we_d : 1'b1;
    n_dbe_d  = (state_d != ENABLE);
    d_out_d  = bus_act ? wdata_d : '0;
    d_oe_d   = bus_act & we_d;
    ack_d    = (state_d == ACK);
    dma_rd_d = (state_d == DMA_RD);
  end

  // State, latched access fields and registered outputs
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdcap_q  <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      rnw_q    <= 1'b1;
      rs_q     <= '0;
      n_dbe_q  <= 1'b1;
      d_out_q  <= '0;
      d_oe_q   <= 1'b0;
      ack_q    <= 1'b0;
      dma_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdcap_q  <= rdcap_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      rnw_q    <= rnw_d;
      rs_q     <= rs_d;
      n_dbe_q  <= n_dbe_d;
      d_out_q  <= d_out_d;
      d_oe_q   <= d_oe_d;
      ack_q    <= ack_d;
      dma_rd_q <= dma_rd_d;
    end
  end

  // Two-flop synchroniser for the active-low PPU interrupt
  always_ff @(posedge CLK) begin
    if (RES) begin
      int_s1_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      int_s1_q <= ~n_INT;
      irq_q    <= int_s1_q;
    end
  end

  assign RnW        = rnw_q;
  assign RS         = rs_q;
  assign n_DBE      = n_dbe_q;
  assign D_out      = d_out_q;
  assign D_oe       = d_oe_q;
  assign host.ack   = ack_q;
  assign host.rdata = rdata_q;
  assign irq        = irq_q;
  assign dma_rd     = DmaEn & dma_rd_q;
  assign dma_idx    = DmaEn ? idx_q : '0;
  assign dma_busy   = DmaEn & busy_q;
  assign dma_done   = DmaEn & done_q;

endmodule
